// File: rtl/ema_lut_loader.sv
// Writer for the EMA coefficient LUTs: sweeps every address and writes alpha*addr and
// (1-alpha)*addr, built up by accumulation so no multiplier is needed.
module ema_lut_loader #(
   parameter int WIDTH  = 8,
   parameter int DATA_W = 16,
   parameter int FRAC   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [FRAC:0]     alpha_in_i,
   input  logic              wr_ready_i,
   output logic              wr_en_o,
   output logic [WIDTH-1:0]  wr_addr_o,
   output logic [DATA_W-1:0] wr_alpha_data_o,
   output logic [DATA_W-1:0] wr_beta_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        state_o
);

   // Handshake: a write is accepted on a cycle where wr_en_o and wr_ready_i are both high;
   // address and data hold their value on every cycle that is not accepted.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      FIN   = 2'd2
   } state_t;

   localparam int ACC_W = WIDTH + FRAC + 1;
   localparam logic [FRAC:0] ONE = {1'b1, {FRAC{1'b0}}};

   state_t           state_q, state_d;
   logic [FRAC:0]    a_q, a_d;
   logic [FRAC:0]    b_q, b_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [ACC_W-1:0] acc_a_q, acc_a_d;
   logic [ACC_W-1:0] acc_b_q, acc_b_d;
   logic             err_q, err_d;

   logic alpha_ok;
   logic accept;

   assign alpha_ok = (alpha_in_i <= ONE);
   assign accept   = (state_q == SWEEP) && wr_ready_i;

   // Truncate the fraction, then clamp anything wider than the LUT word.
   function automatic logic [DATA_W-1:0] scale(input logic [ACC_W-1:0] acc);
      logic [ACC_W-1:0] sh;
      sh = acc >> FRAC;
      if ((ACC_W > DATA_W) && ((sh >> DATA_W) != '0)) begin
         scale = '1;
      end else begin
         scale = DATA_W'(sh);
      end
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i && alpha_ok) state_d = SWEEP;
         SWEEP:   if (accept && (addr_q == '1)) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_en_o         = 1'b0;
      wr_addr_o       = '0;
      wr_alpha_data_o = '0;
      wr_beta_data_o  = '0;
      busy_o          = 1'b0;
      done_o          = 1'b0;
      case (state_q)
         SWEEP: begin
            wr_en_o         = 1'b1;
            busy_o          = 1'b1;
            wr_addr_o       = addr_q;
            wr_alpha_data_o = scale(acc_a_q);
            wr_beta_data_o  = scale(acc_b_q);
         end
         FIN:     done_o = 1'b1;
         default: ;
      endcase
   end

   assign err_o   = err_q;
   assign state_o = state_q;

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      addr_d  = addr_q;
      acc_a_d = acc_a_q;
      acc_b_d = acc_b_q;
      err_d   = 1'b0;
      if (state_q == IDLE) begin
         err_d = start_i && !alpha_ok;
         if (start_i && alpha_ok) begin
            a_d     = alpha_in_i;
            b_d     = ONE - alpha_in_i;
            addr_d  = '0;
            acc_a_d = '0;
            acc_b_d = '0;
         end
      end else if (accept) begin
         addr_d  = addr_q + 1'b1;
         acc_a_d = acc_a_q + ACC_W'(a_q);
         acc_b_d = acc_b_q + ACC_W'(b_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         addr_q  <= '0;
         acc_a_q <= '0;
         acc_b_q <= '0;
         err_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         addr_q  <= addr_d;
         acc_a_q <= acc_a_d;
         acc_b_q <= acc_b_d;
         err_q   <= err_d;
      end
   end

endmodule
